bs_arbiter: RTL and testbench

BS_ARBITER -- requirements
Module: bs_arbiter

---
 rtl/bs_arbiter_pkg.sv | 13 +
 rtl/bs_rot_core.sv | 17 +
 rtl/bs_arbiter.sv | 111 +++++++++++
 tb/tb_bs_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bs_arbiter_pkg.sv
// Shared definitions for the bs_arbiter slice: FSM state encodings and
// the width of the optional grant statistics counters.
package bs_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/bs_rot_core.sv
// Combinational rotate-right of a DW-bit word by an SW-bit amount.
module bs_rot_core #(
  parameter int DW = 4,
  parameter int SW = 2
) (
  input  logic [DW-1:0] din,
  input  logic [SW-1:0] amt,
  output logic [DW-1:0] dout
);

  logic [2*DW-1:0] doubled;

  // Shifting two copies of the word right leaves the rotation in the low half.
  assign doubled = {din, din} >> amt;
  assign dout    = doubled[DW-1:0];

endmodule

// File: rtl/bs_arbiter.sv
// Two-requester round-robin arbiter in front of a rotate-right unit.
// Optional macro BS_ARB_STATS_EN adds saturating per-requester grant counters.
module bs_arbiter
  import bs_arbiter_pkg::*;
#(
  parameter int DW = 4,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  input  logic [SW-1:0] req0_amt,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  input  logic [SW-1:0] req1_amt,
  output logic          req1_ready,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_id,
  output logic          busy
`ifdef BS_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  state_t        state, next_state;
  logic          prio;
  logic          grant_any;
  logic          grant_id;
  logic [DW-1:0] cap_data;
  logic [SW-1:0] cap_amt;
  logic          cap_id;
  logic [DW-1:0] rot_out;

  bs_rot_core #(.DW(DW), .SW(SW)) u_rot (
    .din  (cap_data),
    .amt  (cap_amt),
    .dout (rot_out)
  );

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    next_state = state;
    grant_any  = 1'b0;
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_any  = 1'b1;
          grant_id   = (req0_valid && req1_valid) ? prio : req1_valid;
          next_state = SHIFT;
          req0_ready = rst_n & ~grant_id;
          req1_ready = rst_n & grant_id;
        end
      end
      SHIFT:   next_state = HOLD;
      HOLD:    if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      cap_data  <= '0;
      cap_amt   <= '0;
      cap_id    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_any) begin
        cap_data <= grant_id ? req1_data : req0_data;
        cap_amt  <= grant_id ? req1_amt : req0_amt;
        cap_id   <= grant_id;
        prio     <= ~grant_id;
      end
      if (state == SHIFT) begin
        res_data  <= rot_out;
        res_id    <= cap_id;
        res_valid <= 1'b1;
      end else if (state == HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef BS_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (grant_any) begin
      if (!grant_id && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (grant_id && gnt_cnt1 != '1)  gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bs_arbiter.sv
// Directed self-checking bench for bs_arbiter; define BS_ARB_STATS_EN to
// also exercise the grant counters.
module tb_bs_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_data, req1_data;
  logic [1:0] req0_amt, req1_amt;
  logic       req0_ready, req1_ready;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic       res_id;
  logic       busy;
`ifdef BS_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bs_arbiter #(.DW(4), .SW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy)
`ifdef BS_ARB_STATS_EN
    ,
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] d0, input logic [1:0] a0,
                               input logic v1, input logic [3:0] d1, input logic [1:0] a1);
    req0_valid = v0;
    req0_data  = d0;
    req0_amt   = a0;
    req1_valid = v1;
    req1_data  = d1;
    req1_amt   = a1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 4'b0110, 2'd1, 1'b0, 4'b0000, 2'd0);
    res_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();

    // Reset state, with a request pending that must not see ready
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_data",  32'(res_data),  32'd0);
    checkOutput("rst_res_id",    32'(res_id),    32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
    rst_n = 1'b1;
    #1;

    // Single request on req0: 0110 rotr 1 = 0011
    checkOutput("single_req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("single_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    applyStimulus(1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 2'd0);
    #1;
    checkOutput("single_shift_busy",  32'(busy),       32'd1);
    checkOutput("single_shift_valid", 32'(res_valid),  32'd0);
    checkOutput("single_shift_ready", 32'(req0_ready), 32'd0);
    tick();
    checkOutput("single_res_valid", 32'(res_valid), 32'd1);
    checkOutput("single_res_data",  32'(res_data),  32'b0011);
    checkOutput("single_res_id",    32'(res_id),    32'd0);
    tick();
    checkOutput("single_done_valid", 32'(res_valid), 32'd0);
    checkOutput("single_done_busy",  32'(busy),      32'd0);

    // Fresh reset, then both valid: req0 first, req1 kept pending and served next
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 4'b1001, 2'd2, 1'b1, 4'b0001, 2'd3);
    #1;
    checkOutput("both_req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("both_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    applyStimulus(1'b0, 4'b0000, 2'd0, 1'b1, 4'b0001, 2'd3);
    #1;
    checkOutput("both_shift_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    checkOutput("both_first_data", 32'(res_data),   32'b0110);
    checkOutput("both_first_id",   32'(res_id),     32'd0);
    checkOutput("both_hold_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    checkOutput("both_second_ready", 32'(req1_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 2'd0);
    tick();
    checkOutput("both_second_valid", 32'(res_valid), 32'd1);
    checkOutput("both_second_data",  32'(res_data),  32'b0010);
    checkOutput("both_second_id",    32'(res_id),    32'd1);
    tick();

    // amt=0 pass-through, then a stalled HOLD with both requesters waiting
    res_ready = 1'b0;
    applyStimulus(1'b1, 4'b1010, 2'd0, 1'b0, 4'b0000, 2'd0);
    #1;
    checkOutput("amt0_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 4'b0111, 2'd1, 1'b1, 4'b1100, 2'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold%0d_valid", i), 32'(res_valid), 32'd1);
      checkOutput($sformatf("hold%0d_data", i),  32'(res_data),  32'b1010);
      checkOutput($sformatf("hold%0d_id", i),    32'(res_id),    32'd0);
      checkOutput($sformatf("hold%0d_busy", i),  32'(busy),      32'd1);
      checkOutput($sformatf("hold%0d_r0", i),    32'(req0_ready), 32'd0);
      checkOutput($sformatf("hold%0d_r1", i),    32'(req1_ready), 32'd0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    checkOutput("rr_release_valid", 32'(res_valid),  32'd0);
    checkOutput("rr_req1_ready",    32'(req1_ready), 32'd1);
    checkOutput("rr_req0_ready",    32'(req0_ready), 32'd0);
    tick();

    // Reset in SHIFT: in-flight op discarded, busy drops at once, prio back to req0
    applyStimulus(1'b1, 4'b1100, 2'd3, 1'b1, 4'b0101, 2'd1);
    checkOutput("abort_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy",       32'(busy),       32'd0);
    checkOutput("abort_res_valid",  32'(res_valid),  32'd0);
    checkOutput("abort_req0_ready", 32'(req0_ready), 32'd0);
    tick();
    checkOutput("abort_held_valid", 32'(res_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("abort_prio_req0", 32'(req0_ready), 32'd1);
    checkOutput("abort_prio_req1", 32'(req1_ready), 32'd0);
    tick();
    applyStimulus(1'b0, 4'b0000, 2'd0, 1'b1, 4'b0101, 2'd1);
    tick();
    checkOutput("abort_next_valid", 32'(res_valid), 32'd1);
    checkOutput("abort_next_data",  32'(res_data),  32'b1001);
    checkOutput("abort_next_id",    32'(res_id),    32'd0);
    tick();
    applyStimulus(1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 2'd0);
    tick();
    tick();
    tick();

    // res_ready in IDLE with nothing pending has no effect
    checkOutput("idle_res_valid", 32'(res_valid), 32'd0);
    checkOutput("idle_busy",      32'(busy),      32'd0);

`ifdef BS_ARB_STATS_EN
    // 300 grants to req1 saturate its counter at 255
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    checkOutput("cnt_rst1", 32'(gnt_cnt1), 32'd0);
    applyStimulus(1'b0, 4'b0000, 2'd0, 1'b1, 4'b0011, 2'd1);
    for (int i = 0; i < 900; i++) tick();
    applyStimulus(1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 2'd0);
    tick();
    tick();
    checkOutput("cnt_sat1", 32'(gnt_cnt1), 32'd255);
    checkOutput("cnt_zero0", 32'(gnt_cnt0), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
